// File: rtl/ripple_sum_deskew.sv
// ripple_sum_deskew: realigns staggered ripple-adder sum bits into whole words
// and buffers them in a 2-entry valid/ready queue with sticky drop detection.
module ripple_sum_deskew #(
    parameter int WIDTH     = 4,
    parameter int STAGE_LAT = 1,
    parameter int ADD_LAT   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             launch,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             cout_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             overflow,
    output logic [7:0]       word_count
);
    localparam int L = ADD_LAT + (WIDTH - 1) * STAGE_LAT;
    logic [WIDTH-1:0] aligned;
    logic [L-1:0]     vsr;
    logic [WIDTH:0]   mem [2];
    logic             wr;
    logic             rd;
    logic [1:0]       cnt;
    logic             push;
    logic             pop;
    logic             accept;
    // Earlier bits wait longer so every bit of a launch lands together at t+L.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        localparam int D = (WIDTH - 1 - i) * STAGE_LAT;
        if (D == 0) begin : g_thru
            assign aligned[i] = sum_in[i];
        end else begin : g_sr
            logic [D-1:0] sr;
            always_ff @(posedge clk)
                sr <= rst ? '0 : D'({sr, sum_in[i]});
            assign aligned[i] = sr[D-1];
        end
    end
    always_ff @(posedge clk)
        vsr <= rst ? '0 : L'({vsr, launch});
    assign push   = vsr[L-1];
    assign pop    = out_valid && out_ready;
    // A pop at full frees the slot the same edge, so the push still lands.
    assign accept = push && (cnt != 2'd2 || pop);
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0]     <= '0;
            mem[1]     <= '0;
            wr         <= 1'b0;
            rd         <= 1'b0;
            cnt        <= 2'd0;
            overflow   <= 1'b0;
            word_count <= 8'd0;
        end else begin
            if (accept) begin
                mem[wr]    <= {cout_in, aligned};
                wr         <= ~wr;
                word_count <= word_count + 8'd1;
            end
            if (pop)
                rd <= ~rd;
            cnt <= cnt + 2'(accept) - 2'(pop);
            if (push && !accept)
                overflow <= 1'b1;
        end
    end
    always_comb begin
        out_valid             = cnt != 2'd0;
        {out_cout, out_sum}   = out_valid ? mem[rd] : '0;
    end
endmodule

// File: doc/ripple_sum_deskew.md
# ripple_sum_deskew

Output realignment stage placed directly downstream of the pipelined ripple-carry adder built from `full_adder_1bit` cells. Each sum bit leaves the adder on a different cycle because the carry ripples through clocked stages. This block delays every bit so a whole result word lines up, tags it valid, and buffers it in a 2-entry output queue with a valid/ready handshake. The adder pipeline cannot stall, so the block also detects words lost to back-pressure.

## Interface
- `WIDTH`, 4: adder width in bits.
- `STAGE_LAT`, 1: extra cycles from sum bit i to sum bit i+1 at this block's input.
- `ADD_LAT`, 2: cycles from `launch` to arrival of sum bit 0.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `launch` input 1: one-cycle pulse, high in the cycle operands enter the adder.
- `sum_in` input WIDTH: raw adder sum bits; bit i is meaningful only in its arrival cycle.
- `cout_in` input 1: adder carry out; arrives in the same cycle as `sum_in[WIDTH-1]`.
- `out_valid` output 1: head of output queue holds a word.
- `out_ready` input 1: consumer accepts the head word when high together with `out_valid`.
- `out_sum` output WIDTH: aligned sum word at queue head.
- `out_cout` output 1: aligned carry at queue head.
- `overflow` output 1: sticky; a word was dropped.
- `word_count` output 8: number of words accepted into the queue, modulo 256.

## Operation
- Arrival cycle of bit i, for a launch at cycle t: t + ADD_LAT + i·STAGE_LAT.
- Define L = ADD_LAT + (WIDTH−1)·STAGE_LAT. With the defaults, L = 5.
- Deskew:
  - Bit i passes through a shift register of (WIDTH−1−i)·STAGE_LAT stages; bit WIDTH−1 and `cout_in` pass through zero stages.
  - All bits of one launch therefore present together at cycle t+L.
- Valid tracking:
  - `launch` passes through an L-stage shift register.
  - Its output marks the aligned word at cycle t+L.
  - Back-to-back launches on every cycle are supported, with no gaps required.
- Output queue:
  - 2-entry FIFO with a write pointer, read pointer and 2-bit occupancy count.
  - Push occurs in the cycle the aligned-valid is high; pop occurs when `out_valid && out_ready`.
  - Push and pop in the same cycle, at any occupancy: both take effect, occupancy is unchanged and no overflow occurs. When the queue is full, the pop frees the slot first.
  - Push while full with no pop: the word is discarded, `overflow` is set, and the queue is unchanged.
  - Pop while empty is impossible because `out_valid` is low.
- `word_count` increments on each accepted push and wraps 255 → 0. Dropped words are not counted.
- `sum_in` and `cout_in` values outside their arrival cycles are ignored; no checking is done on them.

## Timing
- Reset values:
  - `out_valid` = 0, `out_sum` = 0, `out_cout` = 0, `overflow` = 0, `word_count` = 0.
  - All deskew and valid shift registers are cleared.
  - Queue is empty.
- Reset mid-operation: every in-flight word, whether in the deskew path or the queue, is discarded. A `launch` sampled during `rst` is ignored. The first launch after reset is released yields `out_valid` at launch+L+1.
- Latency:
  - A word is pushed at the edge ending cycle t+L.
  - `out_valid` rises in cycle t+L+1 if the queue was empty (cycle 6 with the defaults).
- `out_sum` and `out_cout` are driven from the queue head and are stable while `out_valid` is high and `out_ready` is low.
- `overflow` is cleared only by `rst`.

## Test plan
- Single add: launch at cycle 0 with a=1011, b=0110, cin=0. Drive sum bits 1,0,0,0 at cycles 2,3,4,5 and `cout_in`=1 at cycle 5 → cycle 6 shows `out_valid`=1, `out_sum`=0001, `out_cout`=1, `word_count`=1.
- Streaming: launch on cycles 0–7 with distinct sums and `out_ready` held at 1 → eight consecutive valid words on cycles 6–13 in launch order, no `overflow`, `word_count`=8.
- Back-pressure:
  - `out_ready`=0 with launches at cycles 0, 1 and 2 → the queue holds the first two words, `overflow` rises at cycle 8, `word_count`=2.
  - Then raise `out_ready` → the first two words appear in order and the third is never output.
- Full queue with simultaneous push and pop: queue holds 2 words; `out_ready`=1 in the cycle an aligned word arrives → one word is popped, the new word is accepted, `overflow` stays 0 and occupancy stays 2.
- Reset mid-flight: launch at cycles 0 and 1, `rst` high at cycle 3 → no `out_valid` ever appears for those launches; all outputs read 0 from cycle 4.
- Wrap: 256 accepted words → `word_count` returns to 0. Also repeat the single-add test with WIDTH=8 and STAGE_LAT=2 → `out_valid` rises at cycle 2+14+1 = 17.
